indexed_rsh_array: RTL
======================

# indexed_rsh_array

Registered, parametrised array of indexed right-shift-and-insert cells that builds an ordered list of up to `depth_param` entries and then drains it head-first. Each accepted insert places a value at a given position and shifts every entry at or above that position one slot toward the tail in a single cycle. It sits between the sparse-index generator and the SpMM accumulate stage. It replaces per-slot combinational insert cells with one block that has a handshake, occupancy tracking and a fill/drain state machine.

## Interface
- `data_width_param`, 32: entry width.
- `idx_width_param`, 4: insert index width. Must satisfy 2**idx_width_param >= depth_param + 1.
- `depth_param`, 15: number of slots.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `ins_valid`  in  1: insert request.
- `ins_ready`  out  1: insert can be accepted.
- `ins_idx`  in  idx_width_param: target slot; 0 = head.
- `ins_val`  in  data_width_param: value to insert.
- `drain_req`  in  1: pulse; switch to draining.
- `out_valid`  out  1: head entry is presented.
- `out_ready`  in  1: consumer takes the head entry.
- `out_val`  out  data_width_param: head entry, `arr[0]`.
- `count`  out  idx_width_param: occupied slots, 0..depth_param.
- `arr_flat`  out  depth_param*data_width_param: all slots; slot 0 in the LSBs.

## Operation
- States are FILL and DRAIN.
- FILL:
  - `ins_ready` = (count < depth_param).
  - An insert is accepted when `ins_valid && ins_ready`.
  - Effective position p = min(`ins_idx`, count). An index past the tail appends.
  - Per slot i: i < p keeps its value; i == p loads `ins_val`; p < i <= count loads `arr[i-1]`; i > count keeps its value.
  - Each accepted insert increments `count`.
- DRAIN:
  - `ins_ready` = 0.
  - `out_valid` = (count != 0).
  - On `out_valid && out_ready`, every slot i loads `arr[i+1]`, the top slot loads 0, and `count` decrements.
- Transitions:
  - FILL to DRAIN on `drain_req` when count != 0, or when an insert is accepted in the same cycle.
  - `drain_req` with count == 0 and no insert is ignored.
  - DRAIN to FILL on the cycle the last entry is popped (count 1 to 0).
  - `drain_req` is ignored while in DRAIN.
- Simultaneous `ins_valid` and `drain_req` in FILL: the insert is accepted and then DRAIN begins, so the drained set includes that insert.
- Full (count == depth_param): `ins_ready` = 0 and the array holds. A `drain_req` still moves the block to DRAIN.
- Unoccupied slots always read 0.
- Count and index arithmetic is unsigned, width idx_width_param. No wrap can occur, because the clamps above keep count within 0..depth_param.

## Timing
- Reset values: all slots 0, `count` = 0, state FILL, `ins_ready` = 1, `out_valid` = 0, `out_val` = 0.
- Reset asserted mid-fill or mid-drain aborts the operation and clears the array at the next edge.
- Insert latency: an insert accepted at edge N is visible on `arr_flat`/`count` after edge N.
- Throughput: one insert per cycle, and one pop per cycle sustained while `out_ready` is held high.
- `ins_ready`, `out_valid` and `out_val` are functions of registered state only. There is no combinational path from `ins_valid` or `out_ready`.
- The first `out_valid` is asserted in the cycle after the edge at which DRAIN is entered.
- The consumer must hold `out_ready` only as a take signal. `out_val` stays stable while `out_valid && !out_ready`.

## Configuration
- `INDEXED_RSH_SORTED_EN` defined:
  - `ins_idx` is ignored.
  - p = number of occupied slots whose value is <= `ins_val` (unsigned compare), giving ascending order with stable placement of duplicates after existing equal keys.
  - Computed combinationally from the per-cell comparators within the same cycle; latency is unchanged.
- Undefined: p comes from `ins_idx` as above, and no comparators are built.

## Structure
- Package `indexed_rsh_pkg`:
  - state enum (`ST_FILL`, `ST_DRAIN`);
  - cell-select enum (`SEL_KEEP`, `SEL_INS`, `SEL_SHR`, `SEL_SHL`, 2 bits);
  - a function computing per-slot select from (i, p, count, insert, pop).
- Sub-module `indexed_rsh_cell`: one registered slot with a 4:1 select among keep, insert, previous and next. It has a sync reset to 0 and is instantiated `depth_param` times in a generate loop.
- The top level holds the FSM, `count`, the position computation and the handshakes.

## Test plan
Test plan runs with depth_param=4, idx_width_param=3, macro undefined unless noted.
- Reset: after `rst` high for 2 cycles, `count`=0, `ins_ready`=1, `out_valid`=0, `arr_flat`=0.
- Index insert: inserts (idx,val) = (0,10), (0,20), (1,30) on three consecutive cycles give array [20,30,10,0] and `count`=3.
- Clamp and full:
  - Insert (7,40) onto [20,30,10] appends, giving [20,30,10,40], `count`=4, `ins_ready`=0.
  - A 5th insert held on `ins_valid` is not accepted and the array is unchanged.
- Drain with backpressure:
  - After `drain_req` on the full array above, `out_val` gives 20, 30, 10, 40.
  - `out_ready` toggles 1,0,1,1,1; `out_val` holds during the 0 cycle.
  - The block returns to FILL with `count`=0 after the 4th pop.
- Simultaneous events:
  - `ins_valid`(0,5) and `drain_req` in the same cycle on an empty array gives one drained beat, 5, then FILL.
  - `drain_req` alone on an empty array leaves the state at FILL.
  - `rst` asserted after 2 pops clears everything at the next edge.
- `INDEXED_RSH_SORTED_EN`: inserting 50, 20, 50, 10 (with `ins_idx`=0 throughout) gives [10,20,50,50], and the drain emits them in that order.

Source files
------------

// File: rtl/indexed_rsh_pkg.sv
// rtl/indexed_rsh_pkg.sv - shared types and slot-select helper for indexed_rsh_array
//
// Purpose: FSM state enum, per-cell select enum and the function that maps
//          (slot, insert position, occupancy, insert, pop) to a cell select.
// Ports:   none (package).
package indexed_rsh_pkg;

  typedef enum logic {ST_FILL, ST_DRAIN} state_e;

  typedef enum logic [1:0] {SEL_KEEP, SEL_INS, SEL_SHR, SEL_SHL} sel_e;

  // Insert and pop never coincide: insert only happens in FILL, pop only in DRAIN.
  function automatic sel_e slot_sel(input int unsigned i, input int unsigned p,
                                    input int unsigned cnt, input logic insert,
                                    input logic pop);
    if (pop) return SEL_SHL;
    if (insert) begin
      if (i == p) return SEL_INS;
      if (i > p && i <= cnt) return SEL_SHR;
    end
    return SEL_KEEP;
  endfunction

endpackage

// File: rtl/indexed_rsh_cell.sv
// rtl/indexed_rsh_cell.sv - one registered slot of the indexed shift array
//
// Purpose: holds one entry; loads keep / insert value / previous slot / next slot.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (clears slot to 0)
//   sel           : select among keep, insert, previous (shift right), next (shift left)
//   ins_val       : value loaded on SEL_INS
//   prev_val      : slot i-1 contents (0 for the head slot)
//   next_val      : slot i+1 contents (0 for the top slot)
//   q             : slot contents
module indexed_rsh_cell
  import indexed_rsh_pkg::*;
#(
  parameter int data_width_param = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  sel_e                        sel,
  input  logic [data_width_param-1:0] ins_val,
  input  logic [data_width_param-1:0] prev_val,
  input  logic [data_width_param-1:0] next_val,
  output logic [data_width_param-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      unique case (sel)
        SEL_KEEP: q <= q;
        SEL_INS:  q <= ins_val;
        SEL_SHR:  q <= prev_val;
        SEL_SHL:  q <= next_val;
      endcase
    end
  end

endmodule

// File: rtl/indexed_rsh_array.sv
// rtl/indexed_rsh_array.sv - indexed insert-and-shift ordered list with fill/drain FSM
//
// Purpose: builds an ordered list of up to depth_param entries by positional
//          inserts, then drains it head-first with a valid/ready handshake.
// Build option: INDEXED_RSH_SORTED_EN - position comes from per-slot unsigned
//          comparators (ascending, duplicates after equal keys); ins_idx ignored.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   ins_valid/ins_ready  : insert handshake; ins_idx target slot (0 = head), ins_val data
//   drain_req            : pulse, switch from FILL to DRAIN
//   out_valid/out_ready  : drain handshake; out_val is the head slot
//   count                : occupied slots 0..depth_param
//   arr_flat             : all slots, slot 0 in the LSBs
module indexed_rsh_array
  import indexed_rsh_pkg::*;
#(
  parameter int data_width_param = 32,
  parameter int idx_width_param  = 4,
  parameter int depth_param      = 15
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    ins_valid,
  output logic                                    ins_ready,
  input  logic [idx_width_param-1:0]              ins_idx,
  input  logic [data_width_param-1:0]             ins_val,
  input  logic                                    drain_req,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [data_width_param-1:0]             out_val,
  output logic [idx_width_param-1:0]              count,
  output logic [depth_param*data_width_param-1:0] arr_flat
);

  localparam logic [idx_width_param-1:0] depth_c = idx_width_param'(depth_param);
  localparam logic [idx_width_param-1:0] one_c   = idx_width_param'(1);

  state_e                        state;
  logic [idx_width_param-1:0]    pos;
  logic [data_width_param-1:0]   arr [depth_param];
  logic                          accept;
  logic                          pop;

  // Handshake outputs depend on registered state only.
  assign ins_ready = (state == ST_FILL) && (count < depth_c);
  assign out_valid = (state == ST_DRAIN) && (count != '0);
  assign out_val   = arr[0];
  assign accept    = ins_valid && ins_ready;
  assign pop       = out_valid && out_ready;

`ifdef INDEXED_RSH_SORTED_EN
  // Position = number of occupied slots <= ins_val; the list stays ascending
  // and a new duplicate lands after existing equal keys.
  always_comb begin
    pos = '0;
    for (int i = 0; i < depth_param; i++) begin
      if ((idx_width_param'(i) < count) && (arr[i] <= ins_val)) pos = pos + one_c;
    end
  end
`else
  // An index past the tail appends.
  assign pos = (ins_idx > count) ? count : ins_idx;
`endif

  for (genvar g = 0; g < depth_param; g++) begin : g_slot
    logic [data_width_param-1:0] prev_val;
    logic [data_width_param-1:0] next_val;
    sel_e                        sel;

    if (g == 0) begin : g_head
      assign prev_val = '0;
    end else begin : g_prev
      assign prev_val = arr[g-1];
    end

    // The top slot takes 0 on a pop so unoccupied slots always read 0.
    if (g == depth_param - 1) begin : g_top
      assign next_val = '0;
    end else begin : g_next
      assign next_val = arr[g+1];
    end

    assign sel = slot_sel(32'(g), 32'(pos), 32'(count), accept, pop);

    indexed_rsh_cell #(
      .data_width_param(data_width_param)
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .sel      (sel),
      .ins_val  (ins_val),
      .prev_val (prev_val),
      .next_val (next_val),
      .q        (arr[g])
    );

    assign arr_flat[g*data_width_param +: data_width_param] = arr[g];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FILL;
      count <= '0;
    end else begin
      unique case (state)
        ST_FILL: begin
          if (accept) count <= count + one_c;
          // A same-cycle insert counts as content, so the drain includes it.
          if (drain_req && ((count != '0) || accept)) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (pop) begin
            count <= count - one_c;
            if (count == one_c) state <= ST_FILL;
          end
        end
      endcase
    end
  end

endmodule
